// File: rtl/rv32_mem.sv
// rv32_mem: memory pipeline stage; drives the data bus for loads/stores and registers the writeback result.
// Optional: define RV32_MEM_BUS_TIMEOUT_EN to fault accesses left unanswered for TIMEOUT_CYCLES bus cycles.
module rv32_mem #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  exception_cause_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        mem_stall_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  exception_cause_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        zext;
    logic [4:0]  rd_latched;
    logic        rd_write_latched;
    logic [31:0] store_data;
    logic        is_store;
    logic        kill;

    logic        take;
    logic        is_mem;
    logic        misaligned;
    logic        kill_now;
    logic        timeout;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;

    assign take     = valid_in & ~flush_in;
    assign is_mem   = mem_read_in | mem_write_in;
    assign kill_now = kill | flush_in;

    always_comb begin
        misaligned = 1'b0;
        case (mem_width_in)
            2'd1:    misaligned = result_in[0];
            2'd2:    misaligned = (result_in[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Lane selection for the returning load, then sign or zero extension.
    always_comb begin
        load_byte = data_read_value_in[7:0];
        case (addr[1:0])
            2'd0:    load_byte = data_read_value_in[7:0];
            2'd1:    load_byte = data_read_value_in[15:8];
            2'd2:    load_byte = data_read_value_in[23:16];
            default: load_byte = data_read_value_in[31:24];
        endcase
        load_half  = addr[1] ? data_read_value_in[31:16] : data_read_value_in[15:0];
        load_value = data_read_value_in;
        case (width)
            2'd0:    load_value = zext ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_value = zext ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_value = data_read_value_in;
        endcase
    end

    assign data_address_out = {addr[31:2], 2'b00};
    assign data_read_out    = (state == BUSY) & ~is_store;
    assign data_write_out   = (state == BUSY) & is_store;
    assign mem_stall_out    = (state == BUSY) & ~data_ready_in;

    always_comb begin
        data_write_mask_out  = 4'b0000;
        data_write_value_out = store_data;
        case (width)
            2'd0: begin
                data_write_value_out = {4{store_data[7:0]}};
                if (data_write_out) data_write_mask_out = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                data_write_value_out = {2{store_data[15:0]}};
                if (data_write_out) data_write_mask_out = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                data_write_value_out = store_data;
                if (data_write_out) data_write_mask_out = 4'b1111;
            end
        endcase
    end

`ifdef RV32_MEM_BUS_TIMEOUT_EN
    localparam int COUNT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [COUNT_WIDTH-1:0] count;

    // Counts unanswered BUSY cycles; sits at zero whenever the stage is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (state == IDLE) begin
            count <= '0;
        end else if (!data_ready_in) begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

    assign timeout = (state == BUSY) & ~data_ready_in & (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            addr                <= '0;
            width               <= '0;
            zext                <= 1'b0;
            rd_latched          <= '0;
            rd_write_latched    <= 1'b0;
            store_data          <= '0;
            is_store            <= 1'b0;
            kill                <= 1'b0;
            valid_out           <= 1'b0;
            exception_out       <= 1'b0;
            exception_cause_out <= '0;
            rd_out              <= '0;
            rd_write_out        <= 1'b0;
            rd_value_out        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_out              <= rd_in;
                    rd_value_out        <= result_in;
                    exception_out       <= 1'b0;
                    exception_cause_out <= '0;
                    if (take && exception_in) begin
                        valid_out           <= 1'b1;
                        exception_out       <= 1'b1;
                        exception_cause_out <= exception_cause_in;
                        rd_write_out        <= 1'b0;
                    end else if (take && is_mem && misaligned) begin
                        valid_out           <= 1'b1;
                        exception_out       <= 1'b1;
                        exception_cause_out <= mem_write_in ? 4'd6 : 4'd4;
                        rd_write_out        <= 1'b0;
                    end else if (take && is_mem) begin
                        // The result arrives when the bus answers; until then writeback sees a bubble.
                        valid_out        <= 1'b0;
                        rd_write_out     <= 1'b0;
                        addr             <= result_in;
                        width            <= mem_width_in;
                        zext             <= mem_zero_extend_in;
                        rd_latched       <= rd_in;
                        rd_write_latched <= rd_write_in;
                        store_data       <= rs2_value_in;
                        is_store         <= mem_write_in;
                        kill             <= 1'b0;
                        state            <= BUSY;
                    end else begin
                        valid_out    <= take;
                        rd_write_out <= rd_write_in & take;
                    end
                end
                BUSY: begin
                    if (flush_in) kill <= 1'b1;
                    if (data_ready_in) begin
                        state               <= IDLE;
                        valid_out           <= ~kill_now;
                        exception_out       <= 1'b0;
                        exception_cause_out <= '0;
                        rd_out              <= rd_latched;
                        rd_write_out        <= ~is_store & rd_write_latched & ~kill_now;
                        rd_value_out        <= is_store ? 32'h0 : load_value;
                    end else if (timeout) begin
                        state               <= IDLE;
                        valid_out           <= ~kill_now;
                        exception_out       <= ~kill_now;
                        exception_cause_out <= is_store ? 4'd7 : 4'd5;
                        rd_out              <= rd_latched;
                        rd_write_out        <= 1'b0;
                        rd_value_out        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem.sv
// tb_rv32_mem: directed vector table plus randomized traffic checked against a behavioural model of rv32_mem.
// Define RV32_MEM_BUS_TIMEOUT_EN to also exercise the bus timeout fault.
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_in;
    logic        valid_in;
    logic        exception_in;
    logic [3:0]  exception_cause_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  mem_width_in;
    logic        mem_zero_extend_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic [31:0] result_in;
    logic [31:0] rs2_value_in;
    logic [31:0] data_address_out;
    logic        data_read_out;
    logic        data_write_out;
    logic [3:0]  data_write_mask_out;
    logic [31:0] data_write_value_out;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;
    logic        mem_stall_out;
    logic        valid_out;
    logic        exception_out;
    logic [3:0]  exception_cause_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rv32_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush_in             (flush_in),
        .valid_in             (valid_in),
        .exception_in         (exception_in),
        .exception_cause_in   (exception_cause_in),
        .mem_read_in          (mem_read_in),
        .mem_write_in         (mem_write_in),
        .mem_width_in         (mem_width_in),
        .mem_zero_extend_in   (mem_zero_extend_in),
        .rd_in                (rd_in),
        .rd_write_in          (rd_write_in),
        .result_in            (result_in),
        .rs2_value_in         (rs2_value_in),
        .data_address_out     (data_address_out),
        .data_read_out        (data_read_out),
        .data_write_out       (data_write_out),
        .data_write_mask_out  (data_write_mask_out),
        .data_write_value_out (data_write_value_out),
        .data_read_value_in   (data_read_value_in),
        .data_ready_in        (data_ready_in),
        .mem_stall_out        (mem_stall_out),
        .valid_out            (valid_out),
        .exception_out        (exception_out),
        .exception_cause_out  (exception_cause_out),
        .rd_out               (rd_out),
        .rd_write_out         (rd_write_out),
        .rd_value_out         (rd_value_out)
    );

    typedef struct {
        logic        valid;
        logic        flush;
        logic        exc;
        logic [3:0]  cause;
        logic        read;
        logic        write;
        logic [1:0]  width;
        logic        zext;
        logic [4:0]  rd;
        logic        rd_write;
        logic [31:0] result;
        logic [31:0] rs2;
        logic [31:0] bus_data;
        int          delay;
        logic        flush_busy;
    } vec_t;

    typedef struct {
        logic        busy;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        valid;
        logic        exc;
        logic [3:0]  cause;
        logic        rd_write;
        logic [4:0]  rd;
        logic [31:0] rd_value;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } case_t;

    function automatic vec_t mkVec(int valid, int flush, int exc, int cause, int read, int write,
                                   int width, int zext, int rd, int rd_write, logic [31:0] result,
                                   logic [31:0] rs2, logic [31:0] bus_data, int delay, int flush_busy);
        vec_t v;
        v.valid      = 1'(valid);
        v.flush      = 1'(flush);
        v.exc        = 1'(exc);
        v.cause      = 4'(cause);
        v.read       = 1'(read);
        v.write      = 1'(write);
        v.width      = 2'(width);
        v.zext       = 1'(zext);
        v.rd         = 5'(rd);
        v.rd_write   = 1'(rd_write);
        v.result     = result;
        v.rs2        = rs2;
        v.bus_data   = bus_data;
        v.delay      = delay;
        v.flush_busy = 1'(flush_busy);
        return v;
    endfunction

    function automatic exp_t mkExp(int busy, logic [31:0] addr, int mask, logic [31:0] wdata, int valid,
                                   int exc, int cause, int rd_write, int rd, logic [31:0] rd_value);
        exp_t e;
        e.busy     = 1'(busy);
        e.addr     = addr;
        e.mask     = 4'(mask);
        e.wdata    = wdata;
        e.valid    = 1'(valid);
        e.exc      = 1'(exc);
        e.cause    = 4'(cause);
        e.rd_write = 1'(rd_write);
        e.rd       = 5'(rd);
        e.rd_value = rd_value;
        return e;
    endfunction

    // Behavioural reference: what writeback and the bus should see for one instruction.
    function automatic exp_t refModel(vec_t v);
        exp_t        e;
        logic        take;
        logic        mis;
        int          ofs;
        int          val;
        logic [31:0] word;
        e    = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.rd = v.rd;
        take = v.valid && !v.flush;
        ofs  = int'(v.result % 4);
        mis  = (v.width == 2'd1 && (ofs % 2) != 0) || (v.width == 2'd2 && ofs != 0);
        if (take && v.exc) begin
            e.valid = 1'b1;
            e.exc   = 1'b1;
            e.cause = v.cause;
        end else if (take && (v.read || v.write) && mis) begin
            e.valid = 1'b1;
            e.exc   = 1'b1;
            e.cause = v.write ? 4'd6 : 4'd4;
        end else if (take && (v.read || v.write)) begin
            e.busy  = 1'b1;
            e.addr  = v.result - 32'(ofs);
            e.valid = !v.flush_busy;
            if (v.write) begin
                case (v.width)
                    2'd0: begin
                        e.mask  = 4'(1 << ofs);
                        e.wdata = (v.rs2 % 256) * 32'h0101_0101;
                    end
                    2'd1: begin
                        e.mask  = 4'(3 << (ofs - ofs % 2));
                        e.wdata = (v.rs2 % 65536) * 32'h0001_0001;
                    end
                    default: begin
                        e.mask  = 4'hF;
                        e.wdata = v.rs2;
                    end
                endcase
            end else begin
                e.rd_write = v.rd_write && !v.flush_busy;
                case (v.width)
                    2'd0: begin
                        word = (v.bus_data >> (8 * ofs)) % 256;
                        val  = int'(word);
                        if (!v.zext && val >= 128) val = val - 256;
                    end
                    2'd1: begin
                        word = (v.bus_data >> (8 * (ofs - ofs % 2))) % 65536;
                        val  = int'(word);
                        if (!v.zext && val >= 32768) val = val - 65536;
                    end
                    default: val = int'(v.bus_data);
                endcase
                e.rd_value = 32'(val);
            end
        end else begin
            e.valid    = take;
            e.rd_write = v.rd_write && take;
            e.rd_value = v.result;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        valid_in           = 1'b0;
        flush_in           = 1'b0;
        exception_in       = 1'b0;
        exception_cause_in = 4'd0;
        mem_read_in        = 1'b0;
        mem_write_in       = 1'b0;
        mem_width_in       = 2'd0;
        mem_zero_extend_in = 1'b0;
        rd_in              = 5'd0;
        rd_write_in        = 1'b0;
        result_in          = 32'h0;
        rs2_value_in       = 32'h0;
        data_ready_in      = 1'b0;
    endtask

    // Called at a negedge with the stage idle; returns at a negedge with the result registered.
    task automatic applyStimulus(input vec_t v, input exp_t e, input string tag);
        int stalls;
        valid_in           = v.valid;
        flush_in           = v.flush;
        exception_in       = v.exc;
        exception_cause_in = v.cause;
        mem_read_in        = v.read;
        mem_write_in       = v.write;
        mem_width_in       = v.width;
        mem_zero_extend_in = v.zext;
        rd_in              = v.rd;
        rd_write_in        = v.rd_write;
        result_in          = v.result;
        rs2_value_in       = v.rs2;
        data_ready_in      = 1'b0;
        data_read_value_in = $urandom;
        @(negedge clk);
        clearInputs();
        if (e.busy) begin
            checkOutput({tag, " read strobe"}, 32'(data_read_out), 32'(!v.write));
            checkOutput({tag, " write strobe"}, 32'(data_write_out), 32'(v.write));
            checkOutput({tag, " bus address"}, data_address_out, e.addr);
            checkOutput({tag, " bubble valid"}, 32'(valid_out), 32'h0);
            if (v.write) begin
                checkOutput({tag, " write mask"}, 32'(data_write_mask_out), 32'(e.mask));
                checkOutput({tag, " write data"}, data_write_value_out, e.wdata);
            end
            stalls   = 0;
            flush_in = v.flush_busy;
            for (int c = 0; c < v.delay; c++) begin
                if (mem_stall_out) stalls++;
                @(negedge clk);
                flush_in           = 1'b0;
                data_read_value_in = $urandom;
            end
            data_ready_in      = 1'b1;
            data_read_value_in = v.bus_data;
            #1;
            checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(v.delay));
            checkOutput({tag, " stall on ready"}, 32'(mem_stall_out), 32'h0);
            checkOutput({tag, " strobe held"}, 32'(data_read_out | data_write_out), 32'h1);
            @(negedge clk);
            data_ready_in = 1'b0;
            flush_in      = 1'b0;
        end
        checkOutput({tag, " strobes idle"}, 32'(data_read_out | data_write_out), 32'h0);
        checkOutput({tag, " valid_out"}, 32'(valid_out), 32'(e.valid));
        checkOutput({tag, " exception_out"}, 32'(exception_out), 32'(e.exc));
        checkOutput({tag, " rd_write_out"}, 32'(rd_write_out), 32'(e.rd_write));
        if (e.exc) checkOutput({tag, " cause"}, 32'(exception_cause_out), 32'(e.cause));
        if (e.valid) checkOutput({tag, " rd_out"}, 32'(rd_out), 32'(e.rd));
        if (e.rd_write) checkOutput({tag, " rd_value"}, rd_value_out, e.rd_value);
    endtask

    case_t tbl[13];
    vec_t  rv;
    int    n;

    initial begin
        reset              = 1'b1;
        data_read_value_in = 32'h0;
        clearInputs();

        tbl[0]  = '{mkVec(1,0,0,0,1,0,0,0,5,1,32'h1003,0,32'h80FF_0000,3,0),
                    mkExp(1,32'h1000,0,0,1,0,0,1,5,32'hFFFF_FF80)};
        tbl[1]  = '{mkVec(1,0,0,0,1,0,1,1,6,1,32'h2002,0,32'h8001_1234,1,0),
                    mkExp(1,32'h2000,0,0,1,0,0,1,6,32'h0000_8001)};
        tbl[2]  = '{mkVec(1,0,0,0,0,1,1,0,7,1,32'h3002,32'hABCD_1234,0,0,0),
                    mkExp(1,32'h3000,4'hC,32'h1234_1234,1,0,0,0,7,0)};
        tbl[3]  = '{mkVec(1,0,0,0,1,0,2,0,8,1,32'h4001,0,0,0,0),
                    mkExp(0,0,0,0,1,1,4,0,8,0)};
        tbl[4]  = '{mkVec(1,0,0,0,0,1,2,0,9,0,32'h5000,32'hCAFE_F00D,0,2,1),
                    mkExp(1,32'h5000,4'hF,32'hCAFE_F00D,0,0,0,0,9,0)};
        tbl[5]  = '{mkVec(1,0,0,0,0,1,0,0,1,0,32'h6003,32'h1111_115A,0,1,0),
                    mkExp(1,32'h6000,4'h8,32'h5A5A_5A5A,1,0,0,0,1,0)};
        tbl[6]  = '{mkVec(1,0,0,0,0,1,1,0,2,0,32'h6001,0,0,0,0),
                    mkExp(0,0,0,0,1,1,6,0,2,0)};
        tbl[7]  = '{mkVec(1,0,1,2,1,0,2,0,3,1,32'h7000,0,0,0,0),
                    mkExp(0,0,0,0,1,1,2,0,3,0)};
        tbl[8]  = '{mkVec(1,0,0,0,0,0,2,0,10,1,32'hDEAD_BEEF,0,0,0,0),
                    mkExp(0,0,0,0,1,0,0,1,10,32'hDEAD_BEEF)};
        tbl[9]  = '{mkVec(1,1,0,0,0,0,0,0,11,1,32'h1234_5678,0,0,0,0),
                    mkExp(0,0,0,0,0,0,0,0,11,0)};
        tbl[10] = '{mkVec(1,0,0,0,1,0,0,1,12,1,32'h7001,0,32'h0000_9C00,0,0),
                    mkExp(1,32'h7000,0,0,1,0,0,1,12,32'h0000_009C)};
        tbl[11] = '{mkVec(1,0,0,0,1,0,1,0,13,1,32'h8000,0,32'h1234_F00D,2,0),
                    mkExp(1,32'h8000,0,0,1,0,0,1,13,32'hFFFF_F00D)};
        tbl[12] = '{mkVec(1,0,0,0,1,0,2,0,14,1,32'h8004,0,32'h5555_5555,0,1),
                    mkExp(1,32'h8004,0,0,0,0,0,0,14,0)};

        repeat (2) @(negedge clk);
        checkOutput("reset valid_out", 32'(valid_out), 32'h0);
        checkOutput("reset rd_value_out", rd_value_out, 32'h0);
        checkOutput("reset strobes", 32'(data_read_out | data_write_out), 32'h0);
        checkOutput("reset stall", 32'(mem_stall_out), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].v, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Bus ready while idle must not produce a result or start an access.
        data_ready_in = 1'b1;
        @(negedge clk);
        data_ready_in = 1'b0;
        checkOutput("idle ready valid_out", 32'(valid_out), 32'h0);
        checkOutput("idle ready strobes", 32'(data_read_out | data_write_out), 32'h0);

        for (int i = 0; i < 80; i++) begin
            rv = mkVec(int'($urandom % 8 != 0), int'($urandom % 8 == 0), int'($urandom % 10 == 0),
                       int'($urandom % 16), 0, 0, int'($urandom % 3), int'($urandom % 2),
                       int'($urandom % 32), int'($urandom % 4 != 0), $urandom, $urandom, $urandom,
                       int'($urandom % 4), int'($urandom % 6 == 0));
            case ($urandom % 3)
                0:       rv.read  = 1'b1;
                1:       rv.write = 1'b1;
                default: ;
            endcase
            applyStimulus(rv, refModel(rv), $sformatf("rand%0d", i));
        end

`ifdef RV32_MEM_BUS_TIMEOUT_EN
        rv = mkVec(1,0,0,0,1,0,2,0,15,1,32'h9000,0,0,0,0);
        valid_in     = 1'b1;
        mem_read_in  = 1'b1;
        mem_width_in = 2'd2;
        rd_in        = rv.rd;
        rd_write_in  = 1'b1;
        result_in    = rv.result;
        @(negedge clk);
        clearInputs();
        n = 0;
        while (data_read_out && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("timeout busy cycles", 32'(n), 32'd4);
        checkOutput("timeout exception", 32'(exception_out), 32'h1);
        checkOutput("timeout cause", 32'(exception_cause_out), 32'd5);
        checkOutput("timeout rd_write", 32'(rd_write_out), 32'h0);
        checkOutput("timeout strobes", 32'(data_read_out | data_write_out), 32'h0);
        @(negedge clk);
`endif

        // Reset in the middle of an outstanding access abandons it immediately.
        valid_in     = 1'b1;
        mem_read_in  = 1'b1;
        mem_width_in = 2'd2;
        rd_in        = 5'd16;
        rd_write_in  = 1'b1;
        result_in    = 32'hA000;
        @(negedge clk);
        clearInputs();
        checkOutput("pre-reset read strobe", 32'(data_read_out), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset strobes", 32'(data_read_out | data_write_out), 32'h0);
        checkOutput("async reset stall", 32'(mem_stall_out), 32'h0);
        checkOutput("async reset valid_out", 32'(valid_out), 32'h0);
        checkOutput("async reset rd_out", 32'(rd_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        data_ready_in = 1'b1;
        @(negedge clk);
        data_ready_in = 1'b0;
        checkOutput("post-reset valid_out", 32'(valid_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
